imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side counterpart of the instruction fetch path. Receives a program as a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them sequentially into instruction memory through its write port. Holds the core halted (run_o low, wired to the fetch stage's pc_we) until the load completes, then releases it.

Parameters:
ADDR_W, INST_MEM_ADDR_WIDTH, word address width of instruction memory
DATA_W, DATA_WIDTH, instruction word width; fixed at 32
MEM_DEPTH, 2**ADDR_W, number of writable words

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; begin a (re)load at word address 0
s_valid_i  input  1  byte stream valid
s_data_i  input  8  byte stream data, little-endian within each word
s_last_i  input  1  marks final program byte; qualified by s_valid_i
s_ready_o  output  1  loader accepts a byte this cycle
wr_en_o  output  1  instruction memory write strobe
wr_addr_o  output  ADDR_W  instruction memory word address
wr_data_o  output  DATA_W  instruction word to write
run_o  output  1  core may fetch; drives pc_we
busy_o  output  1  load in progress
err_o  output  1  load failed (overflow or checksum)
word_count_o  output  ADDR_W+1  words written in the current/last load

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; word buffer, byte counter, address counter and checksum cleared.
- States: IDLE, LOAD, (CKSUM), RUN, ERROR.
- IDLE: s_ready_o=0, run_o=0. start_i -> LOAD, address=0, word_count=0.
- LOAD: s_ready_o=1, busy_o=1. Byte accepted when s_valid_i && s_ready_o. Byte k (k=0..3) goes to bits [8k+7:8k].
- Fourth byte accepted -> registered write: wr_en_o high for exactly one cycle on the next cycle, with wr_addr_o = current address and wr_data_o = packed word. Address and word_count then increment.
- s_last_i on an accepted byte with k<3: the remaining upper bytes are zero-padded and the word is written the next cycle.
- After the write carrying the last byte: -> RUN (or CKSUM if enabled). run_o rises the cycle after that write strobe.
- Overflow: a byte accepted after the word at MEM_DEPTH-1 has been written -> ERROR. No write is issued and the address does not wrap.
- RUN: run_o=1, busy_o=0, s_ready_o=0. start_i -> LOAD; run_o drops in the same cycle the state changes.
- ERROR: err_o=1, run_o=0, s_ready_o=0. start_i clears err_o -> LOAD.
- start_i during LOAD is ignored. start_i and s_valid_i in the same cycle in IDLE: no byte is accepted that cycle.
- Reset mid-load: returns to IDLE immediately. Partially written memory content is left undefined.
- Zero-length load is not possible: the first s_last_i always produces at least one word.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running XOR of every written word, including the padded last word.
  - After the last program word it enters CKSUM and accepts 4 more bytes (little-endian) without writing them.
  - Received word equals the XOR -> RUN. Otherwise -> ERROR.
  - s_last_i during CKSUM is ignored.
- Undefined: no CKSUM state and no XOR logic; LOAD goes straight to RUN.

Decomposition:
- core_pkg gains:
  - loader_state_t enum (IDLE, LOAD, CKSUM, RUN, ERROR)
  - LOADER_BYTES_PER_WORD = 4
- Natural sub-module: byte_assembler, which owns the byte counter, word buffer, zero-padding and word_valid pulse.
- imem_loader keeps the FSM, address counter, overflow check and checksum.

Test Plan:
- Reset, start_i, 8 bytes 13 00 00 00 93 00 10 00 with s_last_i on the 8th -> writes addr0=0x00000013, addr1=0x00100093. run_o high the cycle after the second wr_en_o; word_count_o=2.
- 5 bytes EF BE AD DE 37, s_last_i on 5th -> addr1=0x00000037 (zero-padded); word_count_o=2.
- s_valid_i toggled randomly across 3 words -> identical writes, no dropped or duplicated bytes, wr_en_o exactly 3 single-cycle pulses.
- MEM_DEPTH=4, 17 bytes -> 4 writes, then err_o=1 and run_o=0. A following start_i clears err_o and restarts at addr0.
- rst_n low after 6 bytes -> all outputs 0 asynchronously. A new start_i reloads from addr0 with byte counter cleared.
- With IMEM_LOADER_CHECKSUM_EN, words 0x00000013, 0x00100093 then checksum bytes 80 00 10 00 -> RUN. Checksum 81 00 10 00 -> err_o=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// The checksum feature is selected with IMEM_LOADER_CHECKSUM_EN in imem_loader.sv.
package imem_loader_pkg;

    localparam int LOADER_BYTES_PER_WORD = 4;
    localparam int LOADER_BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CKSUM,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into words. Emits a one-cycle word_vld pulse
// after the fourth byte, or after an early last byte with the upper bytes zero-padded.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     byte_en,
    input  logic [LOADER_BYTE_W-1:0] byte_data,
    input  logic                     byte_last,
    output logic                     closing,
    output logic                     word_vld,
    output logic                     word_last,
    output logic [DATA_W-1:0]        word_data
);

    localparam int CNT_W = $clog2(LOADER_BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] word_buf_r;
    logic [DATA_W-1:0] merged;

    // The buffer is cleared after every word, so OR-ing in the new byte leaves
    // the not-yet-received upper bytes at zero.
    always_comb begin
        merged  = word_buf_r | (DATA_W'(byte_data) << {cnt_r, 3'b000});
        closing = byte_en &&
                  ((cnt_r == CNT_W'(LOADER_BYTES_PER_WORD - 1)) || byte_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            word_buf_r <= '0;
            word_vld   <= 1'b0;
            word_last  <= 1'b0;
            word_data  <= '0;
        end else if (clr) begin
            cnt_r      <= '0;
            word_buf_r <= '0;
            word_vld   <= 1'b0;
            word_last  <= 1'b0;
            word_data  <= '0;
        end else begin
            word_vld  <= closing;
            word_last <= closing && byte_last;
            if (closing) begin
                word_data  <= merged;
                word_buf_r <= '0;
                cnt_r      <= '0;
            end else if (byte_en) begin
                word_buf_r <= merged;
                cnt_r      <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory and holds the core halted until done.
// Optional trailing XOR checksum word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     s_valid_i,
    input  logic [LOADER_BYTE_W-1:0] s_data_i,
    input  logic                     s_last_i,
    output logic                     s_ready_o,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic                     run_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [ADDR_W:0]          word_count_o
);

    loader_state_t     state_r, state_nx;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;
    logic              fin_pend_r;

    logic              accept;
    logic              start_take;
    logic              full;
    logic              overflow;
    logic              byte_en;
    logic              byte_last;
    logic              final_byte;

    logic              asm_closing;
    logic              asm_word_vld;
    logic              asm_word_last;
    logic [DATA_W-1:0] asm_word_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] xor_r;
`endif

    imem_loader_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_byte_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_take),
        .byte_en   (byte_en),
        .byte_data (s_data_i),
        .byte_last (byte_last),
        .closing   (asm_closing),
        .word_vld  (asm_word_vld),
        .word_last (asm_word_last),
        .word_data (asm_word_data)
    );

    // Memory counts as full once every word slot has been written or is being written
    // this cycle; any further byte is an overflow and never reaches the assembler.
    always_comb begin
        accept     = s_valid_i && s_ready_o;
        start_take = start_i && ((state_r == IDLE) || (state_r == RUN) || (state_r == ERROR));
        full       = (count_r + (ADDR_W + 1)'(asm_word_vld)) == (ADDR_W + 1)'(MEM_DEPTH);
        overflow   = accept && (state_r == LOAD) && full;
        byte_en    = accept && !overflow;
        byte_last  = s_last_i && (state_r == LOAD);
        final_byte = asm_closing && (byte_last || (state_r == CKSUM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        unique case (state_r)
            IDLE: begin
                if (start_i) state_nx = LOAD;
            end
            LOAD: begin
                if (overflow) begin
                    state_nx = ERROR;
                end else if (asm_word_vld && asm_word_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = CKSUM;
`else
                    state_nx = RUN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (asm_word_vld) state_nx = (asm_word_data == xor_r) ? RUN : ERROR;
            end
`endif
            RUN, ERROR: begin
                if (start_i) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Ready drops between the final byte and its word strobe so nothing slips in
    // behind the end of the program or the checksum.
    always_comb begin
        s_ready_o    = ((state_r == LOAD) || (state_r == CKSUM)) && !fin_pend_r;
        busy_o       = (state_r == LOAD) || (state_r == CKSUM);
        run_o        = (state_r == RUN);
        err_o        = (state_r == ERROR);
        wr_en_o      = asm_word_vld && (state_r == LOAD);
        wr_addr_o    = addr_r;
        wr_data_o    = asm_word_data;
        word_count_o = count_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_pend_r <= 1'b0;
        end else if (start_take) begin
            fin_pend_r <= 1'b0;
        end else if (final_byte) begin
            fin_pend_r <= 1'b1;
        end else if (asm_word_vld) begin
            fin_pend_r <= 1'b0;
        end
    end

    // The address saturates at the last slot; the overflow check stops further writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            count_r <= '0;
        end else if (start_take) begin
            addr_r  <= '0;
            count_r <= '0;
        end else if (wr_en_o) begin
            if (addr_r != ADDR_W'(MEM_DEPTH - 1)) addr_r <= addr_r + ADDR_W'(1);
            count_r <= count_r + (ADDR_W + 1)'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_r <= '0;
        end else if (start_take) begin
            xor_r <= '0;
        end else if (wr_en_o) begin
            xor_r <= xor_r ^ asm_word_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory; checksum cases follow
// IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              s_valid_i = 1'b0;
    logic [7:0]        s_data_i = 8'h00;
    logic              s_last_i = 1'b0;
    logic              s_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              run_o;
    logic              busy_o;
    logic              err_o;
    logic [ADDR_W:0]   word_count_o;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .run_o        (run_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;
    wr_t log_q[$];

    always @(negedge clk) if (wr_en_o) log_q.push_back('{wr_addr_o, wr_data_o, cyc});

    typedef struct {
        int          nbytes;
        logic [95:0] bytes;
        int          nwords;
        logic [95:0] words;
        logic [31:0] cksum;
    } case_t;
    case_t cases[3];

    int n_checks = 0;
    int n_fail   = 0;
    int rc;
    int gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        check("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], k == 3);
    endtask

    task automatic wait_run(output int run_cyc);
        run_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (run_o) begin
                run_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("run_reached", 32'(run_cyc >= 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{8,  {32'h0, 32'h00100093, 32'h00000013}, 2,
                     {32'h0, 32'h00100093, 32'h00000013}, 32'h00100080};
        cases[1] = '{5,  {32'h0, 32'h00000037, 32'hDEADBEEF}, 2,
                     {32'h0, 32'h00000037, 32'hDEADBEEF}, 32'hDEADBED8};
        cases[2] = '{12, {32'h0C0B0A09, 32'h08070605, 32'h04030201}, 3,
                     {32'h0C0B0A09, 32'h08070605, 32'h04030201}, 32'h000F0E0D};

        #2;
        check("rst_run",   32'(run_o),        32'd0);
        check("rst_busy",  32'(busy_o),       32'd0);
        check("rst_err",   32'(err_o),        32'd0);
        check("rst_ready", 32'(s_ready_o),    32'd0);
        check("rst_wr_en", 32'(wr_en_o),      32'd0);
        check("rst_count", 32'(word_count_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 3; c++) begin
            log_q.delete();
            if (c == 0) begin
                s_valid_i = 1'b1;
                s_data_i  = 8'hAA;
                start_i   = 1'b1;
                #1;
                check("idle_start_no_accept", 32'(s_ready_o), 32'd0);
                @(posedge clk);
                #1;
                start_i   = 1'b0;
                s_valid_i = 1'b0;
            end else begin
                pulse_start();
                check("restart_run_low", 32'(run_o),  32'd0);
                check("restart_busy",    32'(busy_o), 32'd1);
            end
            for (int b = 0; b < cases[c].nbytes; b++) begin
                if (c == 2) begin
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    if (b == 5) pulse_start();
                end
                send_byte(cases[c].bytes[8*b +: 8], b == cases[c].nbytes - 1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_word(cases[c].cksum);
`endif
            wait_run(rc);
            check($sformatf("c%0d_nwrites", c), 32'(log_q.size()), 32'(cases[c].nwords));
            for (int w = 0; w < cases[c].nwords; w++) begin
                if (w < log_q.size()) begin
                    check($sformatf("c%0d_addr%0d", c, w), 32'(log_q[w].addr), 32'(w));
                    check($sformatf("c%0d_data%0d", c, w), log_q[w].data, cases[c].words[32*w +: 32]);
                end
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (log_q.size() > 0)
                check($sformatf("c%0d_run_timing", c), 32'(rc), 32'(log_q[log_q.size()-1].cyc + 1));
`endif
            check($sformatf("c%0d_word_count", c), 32'(word_count_o), 32'(cases[c].nwords));
            check($sformatf("c%0d_busy", c), 32'(busy_o), 32'd0);
            check($sformatf("c%0d_err", c),  32'(err_o),  32'd0);
        end

        // overflow: 17 bytes into a 4-word memory
        log_q.delete();
        pulse_start();
        for (int b = 0; b < 17; b++) send_byte(8'(8'h20 + b), b == 16);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("ovf_err",     32'(err_o),        32'd1);
        check("ovf_run",     32'(run_o),        32'd0);
        check("ovf_ready",   32'(s_ready_o),    32'd0);
        check("ovf_nwrites", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            check("ovf_data0", log_q[0].data, 32'h23222120);
            check("ovf_addr3", 32'(log_q[3].addr), 32'd3);
            check("ovf_data3", log_q[3].data, 32'h2F2E2D2C);
        end
        log_q.delete();
        pulse_start();
        check("ovf_restart_err",  32'(err_o),  32'd0);
        check("ovf_restart_busy", 32'(busy_o), 32'd1);
        send_word(32'h88776655);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h88776655);
`endif
        wait_run(rc);
        check("ovf_re_nwrites", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            check("ovf_re_addr", 32'(log_q[0].addr), 32'd0);
            check("ovf_re_data", log_q[0].data, 32'h88776655);
        end

        // asynchronous reset in the middle of a load
        pulse_start();
        for (int b = 0; b < 6; b++) send_byte(8'(b + 1), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en",   32'(wr_en_o),      32'd0);
        check("arst_wr_addr", 32'(wr_addr_o),    32'd0);
        check("arst_wr_data", wr_data_o,         32'd0);
        check("arst_run",     32'(run_o),        32'd0);
        check("arst_busy",    32'(busy_o),       32'd0);
        check("arst_err",     32'(err_o),        32'd0);
        check("arst_ready",   32'(s_ready_o),    32'd0);
        check("arst_count",   32'(word_count_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        log_q.delete();
        pulse_start();
        send_word(32'h44332211);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h44332211);
`endif
        wait_run(rc);
        check("arst_re_nwrites", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            check("arst_re_addr", 32'(log_q[0].addr), 32'd0);
            check("arst_re_data", log_q[0].data, 32'h44332211);
        end
        check("arst_re_count", 32'(word_count_o), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // wrong checksum must land in ERROR
        log_q.delete();
        pulse_start();
        for (int b = 0; b < cases[0].nbytes; b++)
            send_byte(cases[0].bytes[8*b +: 8], b == cases[0].nbytes - 1);
        send_word(32'h00100081);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("bad_ck_err",     32'(err_o),        32'd1);
        check("bad_ck_run",     32'(run_o),        32'd0);
        check("bad_ck_nwrites", 32'(log_q.size()), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
